// File: rtl/da2_pkg.sv
// Shared definitions for the PmodDA2 transmit path: frame geometry,
// power-down codes, FSM states and the frame builder.
package da2_pkg;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  // Two don't-care bits, power-down mode, then the sample, MSB first on the wire.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0] pd,
                                                    input logic [DATA_W-1:0] data);
    return {2'b00, pd, data};
  endfunction

endpackage

// File: rtl/da2_bit_timer.sv
// Phase counter for the DA2 link: generates the sclk level, an end-of-bit
// strobe during shifting, and an end-of-gap strobe while nsync is high.
module da2_bit_timer #(
  parameter int CLK_DIV  = 4,
  parameter int SYNC_GAP = 4
) (
  input  logic clock,
  input  logic rst_n,
  input  logic shift_en,
  input  logic gap_en,
  output logic sclk,
  output logic bit_adv,
  output logic gap_done
);

  localparam int PH_MAX = (CLK_DIV > SYNC_GAP) ? CLK_DIV : SYNC_GAP;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] HALF_END = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] GAP_END  = PH_W'(SYNC_GAP - 1);

  logic [PH_W-1:0] phase;
  logic            half_end;

  assign half_end = (phase == HALF_END);
  // A bit ends on the last cycle of its low half; the next bit starts with sclk high.
  assign bit_adv  = shift_en && half_end && !sclk;
  assign gap_done = gap_en && (phase == GAP_END);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      sclk  <= 1'b1;
    end else if (shift_en) begin
      if (half_end) begin
        phase <= '0;
        sclk  <= ~sclk;
      end else begin
        phase <= phase + PH_W'(1);
      end
    end else if (gap_en) begin
      phase <= gap_done ? '0 : phase + PH_W'(1);
      sclk  <= 1'b1;
    end else begin
      phase <= '0;
      sclk  <= 1'b1;
    end
  end

endmodule

// File: rtl/da2_serial_tx.sv
// Dual-channel serial transmitter for the PmodDA2: latches two samples,
// shifts both 16-bit frames MSB-first on d1/d2 under a shared sclk/nsync.
module da2_serial_tx
  import da2_pkg::*;
#(
  parameter int         CLK_DIV  = 4,
  parameter int         SYNC_GAP = 4,
  parameter logic [1:0] PD_MODE  = PD_NORMAL
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic              ready,
  output logic              done,
  output logic              sclk,
  output logic              nsync,
  output logic              d1,
  output logic              d2
);

  state_t             state, state_n;
  logic [FRAME_W-1:0] shift1, shift2;
  logic [3:0]         bit_cnt;
  logic               load, shift, done_n;
  logic               bit_adv, gap_done;

  da2_bit_timer #(
    .CLK_DIV  (CLK_DIV),
    .SYNC_GAP (SYNC_GAP)
  ) u_timer (
    .clock    (clock),
    .rst_n    (rst_n),
    .shift_en (state == SHIFT),
    .gap_en   (state == GAP),
    .sclk     (sclk),
    .bit_adv  (bit_adv),
    .gap_done (gap_done)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    shift   = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && ready) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_adv) begin
          shift = 1'b1;
          if (bit_cnt == 4'd0) state_n = GAP;
        end
      end
      GAP: begin
        if (gap_done) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so pins never see start directly.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      nsync <= 1'b1;
    end else begin
      state <= state_n;
      ready <= (state_n == IDLE);
      done  <= done_n;
      nsync <= (state_n != SHIFT);
    end
  end

  // Shifting past the LSB leaves zeros, which is exactly the idle level of d1/d2.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      shift1  <= '0;
      shift2  <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shift1  <= make_frame(PD_MODE, data1);
      shift2  <= make_frame(PD_MODE, data2);
      bit_cnt <= 4'd15;
    end else if (shift) begin
      shift1  <= {shift1[FRAME_W-2:0], 1'b0};
      shift2  <= {shift2[FRAME_W-2:0], 1'b0};
      if (bit_cnt != 4'd0) bit_cnt <= bit_cnt - 4'd1;
    end
  end

  assign d1 = shift1[FRAME_W-1];
  assign d2 = shift2[FRAME_W-1];

endmodule

// File: tb/tb_da2_serial_tx.sv
// Bench for da2_serial_tx: a default instance and a fast (CLK_DIV=1) instance,
// checked cycle by cycle against an arithmetic timing model plus vector tables.
module tb_da2_serial_tx;

  typedef struct {
    int          dut;
    logic [11:0] a;
    logic [11:0] b;
    logic [15:0] e1;
    logic [15:0] e2;
    int          lat;
    int          low;
  } vec_t;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start_w, ready_w, done_w, sclk_w, nsync_w, d1_w, d2_w;
  logic [11:0] data1_w [2];
  logic [11:0] data2_w [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  da2_serial_tx dut0 (
    .clock (clock), .rst_n (rst_n), .start (start_w[0]),
    .data1 (data1_w[0]), .data2 (data2_w[0]),
    .ready (ready_w[0]), .done (done_w[0]), .sclk (sclk_w[0]),
    .nsync (nsync_w[0]), .d1 (d1_w[0]), .d2 (d2_w[0])
  );

  da2_serial_tx #(.CLK_DIV(1), .SYNC_GAP(1), .PD_MODE(2'b11)) dut1 (
    .clock (clock), .rst_n (rst_n), .start (start_w[1]),
    .data1 (data1_w[1]), .data2 (data2_w[1]),
    .ready (ready_w[1]), .done (done_w[1]), .sclk (sclk_w[1]),
    .nsync (nsync_w[1]), .d1 (d1_w[1]), .d2 (d2_w[1])
  );

  function automatic int cdOf(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int sgOf(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [1:0] pdOf(int i);
    return (i == 0) ? 2'b00 : 2'b11;
  endfunction

  function automatic int periodOf(int i);
    return 32 * cdOf(i) + sgOf(i) + 1;
  endfunction

  // Reference model: remembers the last accepted request per instance.
  int          cyc = 0;
  bit          accValid [2];
  int          accCyc [2];
  logic [15:0] expF1 [2];
  logic [15:0] expF2 [2];

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) accValid[i] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (start_w[i] && (!accValid[i] || cyc >= accCyc[i] + periodOf(i))) begin
          accValid[i] = 1'b1;
          accCyc[i]   = cyc;
          expF1[i]    = {2'b00, pdOf(i), data1_w[i]};
          expF2[i]    = {2'b00, pdOf(i), data2_w[i]};
        end
      end
      cyc++;
    end
  end

  // Expected {ready, done, nsync, sclk, d1, d2} for the current cycle.
  function automatic logic [5:0] expPins(int i);
    logic rdy, dn, ns, sc, a, b;
    int   o, cd, bitIdx;
    rdy = 1'b1; dn = 1'b0; ns = 1'b1; sc = 1'b1; a = 1'b0; b = 1'b0;
    cd  = cdOf(i);
    if (accValid[i]) begin
      if (cyc < accCyc[i] + periodOf(i)) rdy = 1'b0;
      if (cyc == accCyc[i] + periodOf(i)) dn = 1'b1;
      if (cyc >= accCyc[i] + 1 && cyc <= accCyc[i] + 32 * cd) begin
        o      = cyc - accCyc[i] - 1;
        bitIdx = 15 - o / (2 * cd);
        ns     = 1'b0;
        sc     = ((o % (2 * cd)) < cd);
        a      = expF1[i][bitIdx];
        b      = expF2[i][bitIdx];
      end
    end
    return {rdy, dn, ns, sc, a, b};
  endfunction

  function automatic logic [5:0] pinsOf(int i);
    return {ready_w[i], done_w[i], nsync_w[i], sclk_w[i], d1_w[i], d2_w[i]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle pin check plus a DAC-side view: bits captured on sclk falling edges.
  bit          prevSclk [2];
  bit          prevNs [2];
  logic [15:0] cap1 [2];
  logic [15:0] cap2 [2];
  int          falls [2];
  int          lowCnt [2];
  logic [15:0] lastF1 [2];
  logic [15:0] lastF2 [2];
  int          lastFalls [2];
  int          lastLow [2];
  int          frameCnt [2];
  int          doneCnt [2];

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        prevSclk[i] = 1'b1; prevNs[i] = 1'b1;
        cap1[i] = '0; cap2[i] = '0; falls[i] = 0; lowCnt[i] = 0;
      end else begin
        checkOutput((i == 0) ? "pins_dflt" : "pins_fast", 32'(pinsOf(i)), 32'(expPins(i)));
        if (done_w[i]) doneCnt[i]++;
        if (prevSclk[i] && !sclk_w[i]) begin
          cap1[i] = {cap1[i][14:0], d1_w[i]};
          cap2[i] = {cap2[i][14:0], d2_w[i]};
          falls[i]++;
        end
        if (!nsync_w[i]) lowCnt[i]++;
        if (!prevNs[i] && nsync_w[i]) begin
          lastF1[i] = cap1[i]; lastF2[i] = cap2[i];
          lastFalls[i] = falls[i]; lastLow[i] = lowCnt[i];
          frameCnt[i]++;
          cap1[i] = '0; cap2[i] = '0; falls[i] = 0; lowCnt[i] = 0;
        end
        prevSclk[i] = sclk_w[i];
        prevNs[i]   = nsync_w[i];
      end
    end
  end

  task automatic applyStimulus(input int i, input logic [11:0] a, input logic [11:0] b,
                               output int t0);
    @(negedge clock);
    start_w[i] = 1'b1;
    data1_w[i] = a;
    data2_w[i] = b;
    t0 = cyc;
    @(negedge clock);
    start_w[i] = 1'b0;
  endtask

  task automatic waitDone(input int i, input int budget, output int dc, output bit ok);
    ok = 1'b0;
    dc = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clock);
      if (done_w[i]) begin
        dc = cyc;
        ok = 1'b1;
      end
    end
  endtask

  task automatic checkReset();
    for (int i = 0; i < 2; i++)
      checkOutput("reset_pins", 32'(pinsOf(i)), 32'(6'b101100));
  endtask

  task automatic runVec(input vec_t v);
    int t0, dc;
    bit ok;
    applyStimulus(v.dut, v.a, v.b, t0);
    waitDone(v.dut, v.lat + 20, dc, ok);
    checkOutput("done_seen", 32'(ok), 32'd1);
    if (ok) begin
      checkOutput("done_latency", dc - t0, v.lat);
      checkOutput("ready_at_done", 32'(ready_w[v.dut]), 32'd1);
    end
    checkOutput("frame_d1", 32'(lastF1[v.dut]), 32'(v.e1));
    checkOutput("frame_d2", 32'(lastF2[v.dut]), 32'(v.e2));
    checkOutput("sclk_falls", lastFalls[v.dut], 16);
    checkOutput("nsync_low", lastLow[v.dut], v.low);
  endtask

  // start held high while data ramps; each frame must carry its acceptance-cycle data.
  task automatic backToBack(input int i, input int period, input int nFrames,
                            input logic [15:0] last1, input logic [15:0] last2);
    int t0, dc;
    bit ok;
    int dq[$];
    for (int n = 0; n <= (nFrames - 1) * period; n++) begin
      @(negedge clock);
      if (n == 0) t0 = cyc;
      else if (done_w[i]) dq.push_back(cyc);
      start_w[i] = 1'b1;
      data1_w[i] = 12'(12'h100 + n);
      data2_w[i] = ~data1_w[i];
    end
    @(negedge clock);
    start_w[i] = 1'b0;
    waitDone(i, period + 20, dc, ok);
    checkOutput("b2b_done_count", dq.size(), nFrames - 1);
    foreach (dq[k]) checkOutput("b2b_period", dq[k] - t0, period * (k + 1));
    checkOutput("b2b_last_done", ok ? (dc - t0) : -1, period * nFrames);
    checkOutput("b2b_last_d1", 32'(lastF1[i]), 32'(last1));
    checkOutput("b2b_last_d2", 32'(lastF2[i]), 32'(last2));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t tbl [5];
    vec_t rv;
    int   t0, dc, fc, dcnt;
    bit   ok;

    tbl[0] = '{0, 12'hA5C, 12'h3F0, 16'h0A5C, 16'h03F0, 133, 128};
    tbl[1] = '{0, 12'hFFF, 12'h000, 16'h0FFF, 16'h0000, 133, 128};
    tbl[2] = '{0, 12'h001, 12'h800, 16'h0001, 16'h0800, 133, 128};
    tbl[3] = '{1, 12'hFFF, 12'h000, 16'h3FFF, 16'h3000, 34, 32};
    tbl[4] = '{1, 12'h5A5, 12'hA5A, 16'h35A5, 16'h3A5A, 34, 32};

    start_w = '0;
    for (int i = 0; i < 2; i++) begin
      data1_w[i] = '0;
      data2_w[i] = '0;
    end
    repeat (3) @(negedge clock);
    checkReset();
    #2 rst_n = 1'b1;

    foreach (tbl[k]) runVec(tbl[k]);

    // Starts during a busy frame must be dropped, not queued.
    fc   = frameCnt[0];
    dcnt = doneCnt[0];
    applyStimulus(0, 12'h123, 12'h456, t0);
    while (cyc < t0 + 10) @(negedge clock);
    start_w[0] = 1'b1; data1_w[0] = 12'hEEE; data2_w[0] = 12'hDDD;
    @(negedge clock);
    start_w[0] = 1'b0;
    while (cyc < t0 + 100) @(negedge clock);
    start_w[0] = 1'b1; data1_w[0] = 12'hCCC;
    @(negedge clock);
    start_w[0] = 1'b0;
    waitDone(0, 60, dc, ok);
    checkOutput("busy_done_latency", ok ? (dc - t0) : -1, 133);
    checkOutput("busy_frame_d1", 32'(lastF1[0]), 32'h0123);
    checkOutput("busy_frame_d2", 32'(lastF2[0]), 32'h0456);
    repeat (150) @(negedge clock);
    checkOutput("busy_frame_count", frameCnt[0] - fc, 1);
    checkOutput("busy_done_count", doneCnt[0] - dcnt, 1);

    backToBack(0, 133, 4, 16'h028F, 16'h0D70);
    backToBack(1, 34, 3, 16'h3144, 16'h3EBB);

    // Reset in the middle of bit 7 abandons the frame without a done pulse.
    dcnt = doneCnt[0];
    applyStimulus(0, 12'hC3A, 12'h5A5, t0);
    while (cyc < t0 + 60) @(negedge clock);
    #2 rst_n = 1'b0;
    #1 checkReset();
    repeat (2) @(negedge clock);
    #2 rst_n = 1'b1;
    repeat (150) @(negedge clock);
    checkOutput("no_done_after_abort", doneCnt[0] - dcnt, 0);
    rv = '{0, 12'hC3A, 12'h5A5, 16'h0C3A, 16'h05A5, 133, 128};
    runVec(rv);

    // Random traffic on both instances, judged by the per-cycle model.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        start_w[i] = ($urandom_range(0, 15) == 0);
        data1_w[i] = 12'($urandom);
        data2_w[i] = 12'($urandom);
      end
    end
    @(negedge clock);
    start_w = '0;
    repeat (200) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
